// File: rtl/luma_streamer.sv
// luma_streamer: raster-scans a WIDTH x HEIGHT ARGB buffer and streams 8-bit luma
// over a valid/ready interface, one pixel per three cycles.
module luma_streamer #(
    parameter int WIDTH      = 40,
    parameter int HEIGHT     = 30,
    parameter int SIGNED_OUT = 0
) (
    input  logic        read_clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic [5:0]  read_x,
    output logic [4:0]  read_y,
    input  logic [31:0] read_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;

    state_t      state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d, last_q, last_d, done_q, done_d;
    logic [15:0] luma_sum;
    logic [7:0]  luma;
    logic        x_end, y_end, unused_alpha;

    // Weights sum to 256, so the 16-bit sum cannot overflow and Y = sum[15:8].
    assign luma_sum = 16'd77 * 16'(read_q[23:16]) + 16'd150 * 16'(read_q[15:8])
                    + 16'd29 * 16'(read_q[7:0]);
    assign luma = luma_sum[15:8] ^ ((SIGNED_OUT != 0) ? 8'h80 : 8'h00);
    assign unused_alpha = ^read_q[31:24];
    assign x_end = x_q == 6'(WIDTH - 1);
    assign y_end = y_q == 5'(HEIGHT - 1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = ADDR;
                x_d     = '0;
                y_d     = '0;
            end
        end else if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: state_d = DATA;
                DATA: begin
                    data_d  = luma;
                    valid_d = 1'b1;
                    last_d  = x_end && y_end;
                    state_d = OUT;
                end
                OUT: if (out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ADDR;
                        x_d     = x_end ? 6'd0 : x_q + 6'd1;
                        y_d     = x_end ? y_q + 5'd1 : y_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge read_clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy      = state_q != IDLE;
    assign read_x    = x_q;
    assign read_y    = y_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign done      = done_q;
endmodule

// File: tb/tb_luma_streamer.sv
// tb_luma_streamer: directed checks of an unsigned and a signed luma_streamer
// running in lockstep against a registered frame-buffer model.
module tb_luma_streamer;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, rdy = 1'b1;
    logic        busy0, busy1, v0, v1, l0, l1, d0, d1;
    logic [5:0]  x0, x1;
    logic [4:0]  y0, y1;
    logic [7:0]  o0, o1;
    logic [31:0] q0, q1;
    logic [31:0] p00 = 32'hFFFFFFFF, fill = 32'hFFFFFFFF;
    int          tests = 0, fails = 0, act;

    always #5 clk = ~clk;

    function automatic logic [31:0] pix(input logic [5:0] x, input logic [4:0] y);
        return (x == 6'd0 && y == 5'd0) ? p00 : fill;
    endfunction

    always @(posedge clk) begin
        q0 <= pix(x0, y0);
        q1 <= pix(x1, y1);
    end

    luma_streamer #(.SIGNED_OUT(0)) dut0 (
        .read_clock(clk), .reset(reset), .start(start), .abort(abort), .busy(busy0),
        .read_x(x0), .read_y(y0), .read_q(q0), .out_valid(v0), .out_ready(rdy),
        .out_data(o0), .out_last(l0), .done(d0));

    luma_streamer #(.SIGNED_OUT(1)) dut1 (
        .read_clock(clk), .reset(reset), .start(start), .abort(abort), .busy(busy1),
        .read_x(x1), .read_y(y1), .read_q(q1), .out_valid(v1), .out_ready(rdy),
        .out_data(o1), .out_last(l1), .done(d1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Consumes a white frame; optional abort, stray start and 10-cycle stall at given transfer indices.
    task automatic scan(input int abort_at, input int start_at, input int stall_at);
        int n = 0, cyc = 0, stall = 0, bad_d = 0, bad_a = 0, bad_l = 0, bad_s = 0, bad_done = 0;
        bit fin = 1'b0, chk_next = 1'b0;
        logic [8:0] held = '0;
        while (cyc < 6000) begin
            if (fin) begin
                check("done_pulse", {d0, d1}, 2'b11);
                check("idle_after_done", {busy0, busy1}, 2'b00);
                break;
            end
            bad_done += int'(d0 | d1);
            if (chk_next) begin
                check("addr_after_stall", {y0, x0}, {5'd2, 6'd6});
                chk_next = 1'b0;
            end
            if (n == abort_at && v0) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_valid", {v0, v1}, 2'b00);
                check("abort_busy", {busy0, busy1}, 2'b00);
                tick();
                check("abort_no_done", {d0, d1}, 2'b00);
                break;
            end
            start = (n == start_at) && v0;
            if (n == stall_at && v0 && stall < 10) begin
                if (stall == 0) held = {o0, l0};
                else if ({o0, l0, v0} !== {held, 1'b1}) bad_s++;
                rdy = 1'b0;
                stall++;
            end else rdy = 1'b1;
            if (v0 && rdy) begin
                if (o0 !== 8'hFF || o1 !== 8'h7F) bad_d++;
                if (x0 !== 6'(n % 40) || y0 !== 5'(n / 40)) bad_a++;
                if (l0 !== (n == 1199) || l1 !== (n == 1199)) bad_l++;
                if (n == stall_at) chk_next = 1'b1;
                fin = (n == 1199);
                n++;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        rdy = 1'b1;
        check("scan_timeout", cyc < 6000, 1);
        check("transfers", n, (abort_at >= 0) ? abort_at : 1200);
        check("data_errors", bad_d, 0);
        check("addr_errors", bad_a, 0);
        check("last_errors", bad_l, 0);
        check("early_done", bad_done, 0);
        if (stall_at >= 0) begin
            check("stall_cycles", stall, 10);
            check("stall_stability", bad_s, 0);
        end
    endtask

    task automatic colour(input string tag, input logic [31:0] c, input logic [7:0] eu,
                          input logic [7:0] es);
        p00 = c;
        pulse_start();
        tick();
        tick();
        check({tag, "_valid"}, v0, 1);
        check({tag, "_unsigned"}, o0, eu);
        check({tag, "_signed"}, o1, es);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check({tag, "_abort_idle"}, busy0, 0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", {busy0, busy1}, 2'b00);
        check("rst_valid", {v0, v1}, 2'b00);
        check("rst_data", {o0, o1}, 16'h0000);
        check("rst_last_done", {l0, d0}, 2'b00);
        check("rst_addr", {y0, x0}, 11'd0);
        reset = 1'b0;
        tick();
        check("idle_no_start", {busy0, v0}, 2'b00);

        pulse_start();
        check("lat_edge1", v0, 0);
        check("busy_after_start", busy0, 1);
        tick();
        check("lat_edge2", v0, 0);
        tick();
        check("lat_edge3", v0, 1);
        scan(-1, 100, 85);

        colour("red", 32'h00FF0000, 8'd76, 8'hCC);
        colour("green", 32'h0000FF00, 8'd149, 8'h15);
        colour("blue", 32'hFF0000FF, 8'd28, 8'h9C);
        p00 = 32'hFFFFFFFF;

        abort = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_beats_abort", busy0, 1);
        tick();
        tick();
        scan(500, -1, -1);
        pulse_start();
        scan(-1, -1, -1);

        pulse_start();
        repeat (20) tick();
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", {busy0, busy1}, 2'b00);
        check("async_rst_valid", {v0, v1}, 2'b00);
        check("async_rst_data", {o0, o1}, 16'h0000);
        check("async_rst_addr", {y0, x0}, 11'd0);
        tick();
        reset = 1'b0;
        act = 0;
        repeat (20) begin
            tick();
            act += int'(busy0 | v0 | d0);
        end
        check("quiet_after_reset", act, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
